// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package clk_div_pkg;

  typedef enum logic {
    MODE_SQUARE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  localparam int MIN_DIV = 2;

  // Width of a channel index; a single channel still needs one select bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Configuration port of clk_div_multi: one request per cycle, targeting one channel.
// Handshake: a request transfers on a rising edge where cfg_valid and cfg_ready are
// both high; cfg_ch/cfg_div/cfg_mode are only meaningful while cfg_valid is high, and
// cfg_ready may depend combinationally on cfg_ch.
interface clk_div_multi_if
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  localparam int CH_W = ch_w(NUM_CH);

  logic            cfg_valid;
  logic            cfg_ready;
  logic [CH_W-1:0] cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  mode_e           cfg_mode;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, cfg_mode,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, cfg_mode,
    output cfg_ready
  );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, shadow divisor/mode and registered outputs.
// New settings load only at a period wrap or while the channel is held cleared.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_div,
  input  mode_e            cfg_mode,
  output logic             outclk,
  output logic             tick,
  output logic             pending
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] pend_div;
  mode_e            mode;
  mode_e            pend_mode;
  logic             wrap;
  logic             sq_high;

  assign wrap    = (cnt == div - CNT_W'(1));
  assign sq_high = (cnt < (div >> 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      div       <= CNT_W'(DEFAULT_DIV);
      mode      <= MODE_SQUARE;
      pend_div  <= CNT_W'(DEFAULT_DIV);
      pend_mode <= MODE_SQUARE;
      pending   <= 1'b0;
      outclk    <= 1'b0;
      tick      <= 1'b0;
    end else if (en) begin
      cnt    <= wrap ? '0 : cnt + CNT_W'(1);
      tick   <= wrap;
      outclk <= (mode == MODE_PULSE) ? wrap : sq_high;
      if (pending && wrap) begin
        div     <= pend_div;
        mode    <= pend_mode;
        pending <= 1'b0;
      end
      // A running channel only shadows the request; it can never coincide
      // with the apply above because requests are refused while pending.
      if (cfg_we) begin
        pend_div  <= cfg_div;
        pend_mode <= cfg_mode;
        pending   <= 1'b1;
      end
    end else begin
      cnt    <= '0;
      outclk <= 1'b0;
      tick   <= 1'b0;
      if (pending) begin
        div     <= pend_div;
        mode    <= pend_mode;
        pending <= 1'b0;
      end
      if (cfg_we) begin
        div  <= cfg_div;
        mode <= cfg_mode;
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with a shared valid/ready config port.
// Requests to channel indices beyond NUM_CH are accepted and discarded.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 10
) (
  input  logic              inputclock,
  input  logic              rst,
  input  logic [NUM_CH-1:0] enable,
  clk_div_multi_if.slave    cfg,
  output logic [NUM_CH-1:0] outputclock,
  output logic [NUM_CH-1:0] tick
);

  localparam int CH_W = ch_w(NUM_CH);

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] we;
  logic [CNT_W-1:0]  div_c;
  logic              ready_c;
  logic              accept;

  // Divisors below the minimum would make the counter meaningless.
  assign div_c = (cfg.cfg_div < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : cfg.cfg_div;

  always_comb begin
    ready_c = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg.cfg_ch == CH_W'(i)) ready_c = !pending[i];
    end
  end

  assign cfg.cfg_ready = ready_c;
  assign accept        = cfg.cfg_valid && ready_c;

  always_comb begin
    we = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      we[i] = accept && (cfg.cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    clk_div_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk      (inputclock),
      .rst      (rst),
      .en       (enable[g]),
      .cfg_we   (we[g]),
      .cfg_div  (div_c),
      .cfg_mode (cfg.cfg_mode),
      .outclk   (outputclock[g]),
      .tick     (tick[g]),
      .pending  (pending[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: directed scenarios then random traffic, all checked
// against a time-based model (phase = cycles since period start, modulo divisor).
module tb_clk_div_multi;
  import clk_div_pkg::*;

  localparam int NCH  = 6;
  localparam int CW   = 16;
  localparam int DDIV = 10;
  localparam int CHW  = ch_w(NCH);

  logic           clk;
  logic           rst;
  logic [NCH-1:0] enable;
  logic [NCH-1:0] outputclock;
  logic [NCH-1:0] tick;

  clk_div_multi_if #(.NUM_CH(NCH), .CNT_W(CW)) cfg_if ();

  clk_div_multi #(
    .NUM_CH      (NCH),
    .CNT_W       (CW),
    .DEFAULT_DIV (DDIV)
  ) dut (
    .inputclock  (clk),
    .rst         (rst),
    .enable      (enable),
    .cfg         (cfg_if.slave),
    .outputclock (outputclock),
    .tick        (tick)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [2*NCH-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // reference model: phase of channel i at edge t is (t - m_start[i]) % m_div[i]
  int m_div[NCH], m_mode[NCH], m_pdiv[NCH], m_pmode[NCH];
  int m_pend[NCH], m_run[NCH], m_start[NCH];
  int t = 0;

  function automatic int coerce(input int d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

  function automatic bit model_ready(input int ch);
    if (ch >= NCH) return 1'b1;
    return m_pend[ch] == 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_div[i] = DDIV; m_mode[i] = 0; m_pend[i] = 0; m_run[i] = 0; m_start[i] = 0;
      m_pdiv[i] = DDIV; m_pmode[i] = 0;
    end
  endtask

  task automatic model_edge(input bit r, input logic [NCH-1:0] en, input bit acc,
                            input int ch, input int d, input int md,
                            output logic [2*NCH-1:0] exp_out);
    logic [NCH-1:0] e_tick, e_clk;
    int pos;
    bit last;
    e_tick = '0; e_clk = '0;
    if (r) begin
      model_reset();
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (en[i]) begin
          if (!m_run[i]) begin m_run[i] = 1; m_start[i] = t; end
          pos  = (t - m_start[i]) % m_div[i];
          last = (pos == m_div[i] - 1);
          e_tick[i] = last;
          e_clk[i]  = (m_mode[i] == 1) ? last : (pos < m_div[i] / 2);
          if (last && m_pend[i] != 0) begin
            m_div[i] = m_pdiv[i]; m_mode[i] = m_pmode[i]; m_pend[i] = 0;
            m_start[i] = t + 1;
          end
          if (acc && ch == i) begin
            m_pdiv[i] = coerce(d); m_pmode[i] = md; m_pend[i] = 1;
          end
        end else begin
          m_run[i] = 0;
          if (m_pend[i] != 0) begin
            m_div[i] = m_pdiv[i]; m_mode[i] = m_pmode[i]; m_pend[i] = 0;
          end
          if (acc && ch == i) begin
            m_div[i] = coerce(d); m_mode[i] = md;
          end
        end
      end
    end
    exp_out = {e_tick, e_clk};
    t++;
  endtask

  // driver: one cycle of stimulus, checked before and after the edge
  task automatic cycle(input bit r, input logic [NCH-1:0] en, input bit v,
                       input int ch, input int d, input int md);
    logic [2*NCH-1:0] e, got;
    bit acc;
    @(negedge clk);
    rst              = r;
    enable           = en;
    cfg_if.cfg_valid = v;
    cfg_if.cfg_ch    = CHW'(ch);
    cfg_if.cfg_div   = CW'(d);
    cfg_if.cfg_mode  = mode_e'(md[0]);
    #1;
    check("cfg_ready", 32'(cfg_if.cfg_ready), 32'(model_ready(ch)));
    acc = v && model_ready(ch) && !r;
    @(posedge clk);
    model_edge(r, en, acc, ch, d, md, e);
    exp_q.push_back(e);
    #1;
    got = {tick, outputclock};
    e = exp_q.pop_front();
    check("tick", 32'(got[2*NCH-1:NCH]), 32'(e[2*NCH-1:NCH]));
    check("outputclock", 32'(got[NCH-1:0]), 32'(e[NCH-1:0]));
  endtask

  task automatic idle(input logic [NCH-1:0] en, input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, en, 1'b0, 0, 0, 0);
  endtask

  initial begin
    logic [NCH-1:0] en;
    rst = 1'b1; enable = '0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_div = '0;
    cfg_if.cfg_mode = MODE_SQUARE;
    model_reset();

    // reset state
    for (int k = 0; k < 3; k++) cycle(1'b1, '0, 1'b0, 0, 0, 0);

    // default divisor on channel 0
    en = 6'b000001;
    idle(en, 25);

    // ch1 programmed while disabled, then live reprogram to pulse D=3
    cycle(1'b0, en, 1'b1, 1, 5, 0);
    en = 6'b000011;
    idle(en, 12);
    cycle(1'b0, en, 1'b1, 1, 3, 1);
    for (int k = 0; k < 4; k++) cycle(1'b0, en, 1'b1, 1, 7, 0);
    idle(en, 12);

    // divisor coercion: 0 while disabled, 1 while running
    cycle(1'b0, en, 1'b1, 2, 0, 0);
    en = 6'b000111;
    idle(en, 6);
    cycle(1'b0, en, 1'b1, 2, 1, 0);
    idle(en, 8);

    // ch0 request lands near its wrap; retry while pending; ch3 and discard channels
    for (int k = 0; k < 10; k++) cycle(1'b0, en, 1'b1, 0, 4, 0);
    cycle(1'b0, en, 1'b1, 3, 6, 1);
    cycle(1'b0, en, 1'b1, 7, 9, 0);
    cycle(1'b0, en, 1'b1, 6, 9, 1);
    idle(en, 10);

    // drop enable mid-period, then restart
    en = 6'b000110;
    idle(en, 3);
    en = 6'b000111;
    idle(en, 8);

    // pending request on a running channel, then reset with a request on the same edge
    en = 6'b001111;
    cycle(1'b0, en, 1'b1, 3, 3, 0);
    cycle(1'b1, en, 1'b1, 2, 7, 1);
    idle(en, 15);

    // randomized traffic
    for (int k = 0; k < 2500; k++) begin
      for (int i = 0; i < NCH; i++) if ($urandom_range(0, 29) == 0) en[i] = ~en[i];
      cycle(($urandom_range(0, 399) == 0), en, ($urandom_range(0, 3) == 0),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 12)),
            int'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
Parametrised multi-channel clock divider. It generates NUM_CH independent divided outputs from inputclock. Each channel has a run-time programmable divisor and mode (square wave or single-cycle pulse) and a per-channel tick strobe. Divisor and mode are reconfigured through a valid/ready port, with updates applied glitch-free at period boundaries. It replaces the fixed single-ratio divider and feeds the UART baud generator, the motor PWM timebase and the sensor-poll timer from one block.

Parameters:
NUM_CH, 4, number of independent divider channels (1..16)
CNT_W, 16, divisor/counter width in bits
DEFAULT_DIV, 10, divisor loaded into every channel at reset (must be >= 2)

Ports:
inputclock  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous, active-high reset
enable  input  NUM_CH  per-channel run enable
cfg_valid  input  1  config request valid
cfg_ready  output  1  config request can be accepted
cfg_ch  input  max(1,$clog2(NUM_CH))  target channel of config request
cfg_div  input  CNT_W  requested divisor D
cfg_mode  input  1  0 = square, 1 = pulse
outputclock  output  NUM_CH  divided output per channel, driven from a flop
tick  output  NUM_CH  one-cycle strobe per channel period, driven from a flop

Behaviour:
- Interface: one clock (inputclock); reset rst is synchronous and active-high.
- Reset (rst=1 at an edge): every channel gets cnt=0, div=DEFAULT_DIV, mode=square, pending=0, outputclock=0, tick=0. rst overrides all other inputs, including a cfg handshake on the same edge (the request is dropped).
- Per-channel state: cnt[CNT_W], div, mode, pend_div, pend_mode, pending flag. H = div>>1.
- Edge with enable[i]=1:
  - cnt <= (cnt==div-1) ? 0 : cnt+1.
  - tick <= (cnt==div-1).
  - square mode: outputclock <= (cnt < H). Gives high for H cycles and low for div-H cycles, period div. Odd div is low-biased, e.g. D=5 gives 2 high, 3 low.
  - pulse mode: outputclock <= (cnt==div-1), identical to tick.
  - First edge after enable rises: cnt=1, outputclock=1 (square). tick precedes each outputclock rise by 1 cycle.
- Edge with enable[i]=0: cnt<=0, outputclock<=0, tick<=0. The channel is held cleared, not frozen.
- Divisor coercion: cfg_div < 2 (0 or 1) is stored as 2. No error is flagged.
- Config handshake:
  - cfg_ready = !pending[cfg_ch] (combinational from cfg_ch).
  - A request is accepted on an edge with cfg_valid & cfg_ready.
  - cfg_ch >= NUM_CH: cfg_ready=1, the request is accepted and discarded.
- Application timing:
  - If enable[cfg_ch]=0 at the accepting edge: div/mode are written directly at that edge, pending stays 0.
  - Otherwise pend_div/pend_mode are written and pending<=1. At the first later enabled edge where cnt==div-1, div<=pend_div, mode<=pend_mode, pending<=0. The current period therefore completes with the old values.
  - Accept on the same edge as a wrap: goes to pending and applies at the next wrap, not the current one.
  - Channel disabled while pending=1: the pending values are applied at the next edge with enable low.
- Channels are fully independent; only one config is accepted per cycle.
- cnt never exceeds div-1, including after reconfiguration, because a new div only loads at cnt==div-1 or while cleared.

Decomposition:
- Package clk_div_pkg holds:
  - mode typedef (MODE_SQUARE=0, MODE_PULSE=1)
  - MIN_DIV=2 constant
  - channel-index width function
- Sub-module clk_div_chan: one channel with its counter, shadow registers and output flops, exposing a cfg strobe and a pending status.
- Top clk_div_multi: generate-instantiates NUM_CH copies of clk_div_chan, plus the cfg_ch decode and the cfg_ready mux.

Test Plan:
1. Reset, then enable[0]=1 with DEFAULT_DIV=10 -> outputclock[0] high 5 cycles, low 5 cycles, repeating; tick[0] high 1 cycle every 10, one cycle before each rise; other channels stay 0.
2. With channel 1 disabled, cfg ch1 D=5 mode=square, then enable -> pattern 1,1,0,0,0 repeating. Then cfg D=3 mode=pulse while running -> cfg_ready low until the wrap; the old 5-cycle period completes, then 1-of-3 pulses on outputclock[1] equal to tick[1].
3. cfg ch2 D=0, then D=1 -> channel behaves as D=2: outputclock toggles every cycle, tick every 2nd cycle.
4. Accept a cfg on the exact wrap edge of ch0 -> the old period repeats once more, then the new D applies. A second request to ch0 while pending -> cfg_ready=0 and no accept; a request to ch3 in the same cycle -> accepted.
5. Deassert enable[0] mid-period -> at the next edge cnt=0 and outputclock=tick=0. Re-enable -> restarts from phase 0.
6. Assert rst mid-operation with a pending cfg and a cfg_valid on the same edge -> all outputs 0, div=10 everywhere, pending cleared, request dropped.
